pwm_channel_ctrl: RTL and testbench

PWM_CHANNEL_CTRL -- requirements
Module: pwm_channel_ctrl

---
 rtl/pwm_channel_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pwm_channel_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel_ctrl.sv
// Single-channel two-edge PWM whose new period/compare set only takes effect at a period boundary.
// Define PWM_PRESCALER_EN to add the prescale_i tick divider.

module pwm_find_smaller #(
  parameter int Resolution = 16
) (
  input  logic [Resolution-1:0] a,
  input  logic [Resolution-1:0] b,
  output logic [Resolution-1:0] smaller,
  output logic [Resolution-1:0] larger
);

  // order the two compare values
  always_comb begin
    if (a < b) begin
      smaller = a;
      larger  = b;
    end else begin
      smaller = b;
      larger  = a;
    end
  end

endmodule

module pwm_channel_ctrl #(
  parameter int Resolution = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [Resolution-1:0] period_i,
  input  logic [Resolution-1:0] cmp_a_i,
  input  logic [Resolution-1:0] cmp_b_i,
  input  logic                  upd_req_i,
`ifdef PWM_PRESCALER_EN
  input  logic [15:0]           prescale_i,
`endif
  output logic                  upd_ack_o,
  output logic                  pwm_o,
  output logic [Resolution-1:0] cnt_o,
  output logic                  period_end_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [Resolution-1:0] ZERO = {Resolution{1'b0}};
  localparam logic [Resolution-1:0] ONE  = {{(Resolution-1){1'b0}}, 1'b1};

  logic [0:0]            state_r;
  logic [0:0]            state_nxt_s;
  logic [Resolution-1:0] cnt_r;
  logic [Resolution-1:0] cnt_nxt_s;
  logic [Resolution-1:0] period_r;
  logic [Resolution-1:0] lo_r;
  logic [Resolution-1:0] hi_r;
  logic [Resolution-1:0] cmp_lo_s;
  logic [Resolution-1:0] cmp_hi_s;
  logic                  armed_r;
  logic                  tick_s;
  logic                  wrap_s;
  logic                  boundary_s;
  logic                  load_s;
  logic                  active_s;
  logic                  window_s;

  pwm_find_smaller #(
    .Resolution(Resolution)
  ) u_order (
    .a       (cmp_a_i),
    .b       (cmp_b_i),
    .smaller (cmp_lo_s),
    .larger  (cmp_hi_s)
  );

`ifdef PWM_PRESCALER_EN
  logic [15:0] psc_r;
  logic [15:0] psc_lim_r;

  // prescaler; the divide ratio is only re-sampled at a rollover so a period never stretches mid-tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psc_r     <= 16'd0;
      psc_lim_r <= 16'd0;
    end else if (!active_s) begin
      psc_r     <= 16'd0;
      psc_lim_r <= prescale_i;
    end else if (psc_r == psc_lim_r) begin
      psc_r     <= 16'd0;
      psc_lim_r <= prescale_i;
    end else begin
      psc_r     <= psc_r + 16'd1;
      psc_lim_r <= psc_lim_r;
    end
  end

  assign tick_s = (state_r == RUN) && (psc_r == psc_lim_r);
`else
  assign tick_s = (state_r == RUN);
`endif

  // period bookkeeping, update gating and next-state decode
  always_comb begin
    active_s   = (state_r == RUN) && en_i;
    wrap_s     = tick_s && (period_r != ZERO) && (cnt_r == (period_r - ONE));
    // a zero period makes every tick a boundary so a stuck channel can still be reprogrammed
    boundary_s = (state_r == IDLE) || (tick_s && ((period_r == ZERO) || wrap_s));
    load_s     = upd_req_i && armed_r && boundary_s;
    window_s   = (cnt_r >= lo_r) && (cnt_r < hi_r) && (cnt_r < period_r);

    if (!active_s) begin
      cnt_nxt_s = ZERO;
    end else if (!tick_s) begin
      cnt_nxt_s = cnt_r;
    end else if (wrap_s || (period_r == ZERO)) begin
      cnt_nxt_s = ZERO;
    end else begin
      cnt_nxt_s = cnt_r + ONE;
    end

    case (state_r)
      IDLE:    state_nxt_s = en_i ? RUN : IDLE;
      RUN:     state_nxt_s = en_i ? RUN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO;
      pwm_o        <= 1'b0;
      period_end_o <= 1'b0;
      upd_ack_o    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pwm_o        <= active_s && window_s;
      period_end_o <= wrap_s;
      upd_ack_o    <= load_s;
    end
  end

  // active compare set; armed_r enforces one ack per request and a low cycle between requests
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_r <= ZERO;
      lo_r     <= ZERO;
      hi_r     <= ZERO;
      armed_r  <= 1'b1;
    end else if (load_s) begin
      period_r <= period_i;
      lo_r     <= cmp_lo_s;
      hi_r     <= cmp_hi_s;
      armed_r  <= 1'b0;
    end else begin
      period_r <= period_r;
      lo_r     <= lo_r;
      hi_r     <= hi_r;
      armed_r  <= armed_r | ~upd_req_i;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: tb/tb_pwm_channel_ctrl.sv
// Self-checking bench for pwm_channel_ctrl: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.

module tb_pwm_channel_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        upd_req_i;
  logic [15:0] period_i;
  logic [15:0] cmp_a_i;
  logic [15:0] cmp_b_i;
`ifdef PWM_PRESCALER_EN
  logic [15:0] prescale_i;
`endif
  logic        upd_ack_o;
  logic        pwm_o;
  logic [15:0] cnt_o;
  logic        period_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_run, m_armed, m_pwm, m_pend, m_ack;
  int m_cnt, m_period, m_lo, m_hi, m_psc, m_psc_lim;

  always #5 clk = ~clk;

  pwm_channel_ctrl #(.Resolution(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .period_i     (period_i),
    .cmp_a_i      (cmp_a_i),
    .cmp_b_i      (cmp_b_i),
    .upd_req_i    (upd_req_i),
`ifdef PWM_PRESCALER_EN
    .prescale_i   (prescale_i),
`endif
    .upd_ack_o    (upd_ack_o),
    .pwm_o        (pwm_o),
    .cnt_o        (cnt_o),
    .period_end_o (period_end_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_psc = 0; m_psc_lim = 0;
    m_period = 0; m_lo = 0; m_hi = 0;
    m_pwm = 1'b0; m_ack = 1'b0; m_pend = 1'b0; m_armed = 1'b1;
  endtask

  // one rising edge of the specified behaviour, evaluated on the pre-edge state
  task automatic model_edge();
    bit tick, wrap, bnd, load, act;
    int n_cnt;
    act = m_run && en_i;
`ifdef PWM_PRESCALER_EN
    tick = m_run && (m_psc == m_psc_lim);
`else
    tick = m_run;
`endif
    wrap = tick && (m_period != 0) && (m_cnt == m_period - 1);
    bnd  = !m_run || (tick && (m_period == 0 || wrap));
    load = upd_req_i && m_armed && bnd;
    m_pwm  = act && (m_cnt >= m_lo) && (m_cnt < m_hi) && (m_cnt < m_period);
    m_pend = wrap;
    m_ack  = load;
    if (!act) n_cnt = 0;
    else if (tick) n_cnt = (m_period == 0) ? 0 : (m_cnt + 1) % m_period;
    else n_cnt = m_cnt;
`ifdef PWM_PRESCALER_EN
    if (!act || tick) begin
      m_psc = 0;
      m_psc_lim = int'(prescale_i);
    end else begin
      m_psc = m_psc + 1;
    end
`endif
    if (load) begin
      m_period = int'(period_i);
      m_lo = (cmp_a_i < cmp_b_i) ? int'(cmp_a_i) : int'(cmp_b_i);
      m_hi = (cmp_a_i < cmp_b_i) ? int'(cmp_b_i) : int'(cmp_a_i);
      m_armed = 1'b0;
    end else if (!upd_req_i) begin
      m_armed = 1'b1;
    end
    m_cnt = n_cnt;
    m_run = en_i;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_ni) model_reset();
    else model_edge();
    #1;
    check_eq("pwm_o", pwm_o, m_pwm);
    check_eq("cnt_o", cnt_o, m_cnt);
    check_eq("period_end_o", period_end_o, m_pend);
    check_eq("upd_ack_o", upd_ack_o, m_ack);
  endtask

  task automatic do_update(input int p, input int a, input int b, output int lat, output int highs);
    bit got;
    period_i = p[15:0]; cmp_a_i = a[15:0]; cmp_b_i = b[15:0];
    upd_req_i = 1'b1;
    lat = 0; highs = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle();
      lat++;
      highs += int'(pwm_o);
      got = upd_ack_o;
    end
    if (!got) check_eq("ack_timeout", 32'(got), 32'd1);
    upd_req_i = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 200 && cnt_o != v[15:0]; i++) cycle();
    if (cnt_o != v[15:0]) check_eq("wait_cnt", cnt_o, v);
  endtask

  task automatic count_run(input int n, output int highs, output int pends, output int nonzero);
    highs = 0; pends = 0; nonzero = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      highs += int'(pwm_o);
      pends += int'(period_end_o);
      nonzero += int'(cnt_o != 16'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, highs, pends, nz, gap;
    bit just_dropped;
    rst_ni = 1'b1; en_i = 1'b0; upd_req_i = 1'b0;
    period_i = 16'd0; cmp_a_i = 16'd0; cmp_b_i = 16'd0;
`ifdef PWM_PRESCALER_EN
    prescale_i = 16'd0;
`endif
    #1 rst_ni = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pwm", pwm_o, 32'd0);
    check_eq("rst_cnt", cnt_o, 32'd0);
    check_eq("rst_pend", period_end_o, 32'd0);
    check_eq("rst_ack", upd_ack_o, 32'd0);
    repeat (2) cycle();
    rst_ni = 1'b1;
    cycle();

    // load duty in IDLE, then run
    do_update(10, 7, 2, lat, highs);
    check_eq("idle_ack_lat", lat, 32'd1);
    en_i = 1'b1;
    repeat (5) cycle();
    count_run(20, highs, pends, nz);
    check_eq("duty_highs", highs, 32'd10);
    check_eq("duty_pends", pends, 32'd2);

    // mid-period update to an empty window
    wait_cnt(3);
    do_update(10, 4, 4, lat, highs);
    check_eq("midper_ack_lat", lat, 32'd7);
    check_eq("midper_cur_highs", highs, 32'd4);
    count_run(10, highs, pends, nz);
    check_eq("empty_window_highs", highs, 32'd0);

    // clipping of hi beyond the period
    do_update(8, 3, 20, lat, highs);
    repeat (2) cycle();
    count_run(16, highs, pends, nz);
    check_eq("clip_highs", highs, 32'd10);

    // zero period
    do_update(0, 1, 3, lat, highs);
    count_run(50, highs, pends, nz);
    check_eq("zero_pends", pends, 32'd0);
    check_eq("zero_highs", highs, 32'd0);
    check_eq("zero_cnt_nonzero", nz, 32'd0);
    do_update(4, 0, 2, lat, highs);
    check_eq("zero_ack_lat", lat, 32'd1);

    // disable on the wrap cycle still applies the pending update
    wait_cnt(3);
    period_i = 16'd6; cmp_a_i = 16'd4; cmp_b_i = 16'd1;
    upd_req_i = 1'b1; en_i = 1'b0;
    cycle();
    check_eq("dis_wrap_ack", upd_ack_o, 32'd1);
    upd_req_i = 1'b0;
    cycle();
    en_i = 1'b1;
    repeat (3) cycle();
    count_run(12, highs, pends, nz);
    check_eq("dis_wrap_new_highs", highs, 32'd6);

`ifdef PWM_PRESCALER_EN
    prescale_i = 16'd2;
    do_update(4, 0, 2, lat, highs);
    for (int i = 0; i < 100 && !period_end_o; i++) cycle();
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      gap++;
      if (period_end_o) break;
    end
    check_eq("prescale_gap", gap, 32'd12);
    prescale_i = 16'd0;
`endif

    // random traffic
    just_dropped = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en_i = ($urandom_range(0, 15) != 0);
      if (!upd_req_i && !just_dropped && $urandom_range(0, 5) == 0) begin
        period_i = 16'($urandom_range(0, 12));
        cmp_a_i  = 16'($urandom_range(0, 15));
        cmp_b_i  = 16'($urandom_range(0, 15));
        upd_req_i = 1'b1;
      end
`ifdef PWM_PRESCALER_EN
      if ($urandom_range(0, 31) == 0) prescale_i = 16'($urandom_range(0, 3));
`endif
      just_dropped = 1'b0;
      cycle();
      if (upd_req_i && upd_ack_o) begin
        upd_req_i = 1'b0;
        just_dropped = 1'b1;
      end
    end
    upd_req_i = 1'b0;
    en_i = 1'b1;
    cycle();

    // asynchronous reset in the middle of a high phase
    do_update(10, 2, 7, lat, highs);
    wait_cnt(5);
    check_eq("pre_rst_pwm", pwm_o, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_pwm", pwm_o, 32'd0);
    check_eq("async_rst_cnt", cnt_o, 32'd0);
    check_eq("async_rst_pend", period_end_o, 32'd0);
    check_eq("async_rst_ack", upd_ack_o, 32'd0);
    repeat (2) cycle();
    rst_ni = 1'b1;
    count_run(8, highs, pends, nz);
    check_eq("post_rst_highs", highs, 32'd0);
    check_eq("post_rst_cnt_nonzero", nz, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
